// File: rtl/crossbar_rr_arbiter_pkg.sv
// Shared types and helpers for the crossbar output-port arbiter.
// Port count, one-hot select type, arbiter state encoding.
package crossbar_pkg;

    localparam int N_PORTS = 6;
    localparam int PTR_W   = $clog2(N_PORTS);

    typedef logic [N_PORTS-1:0] onehot_t;
    typedef logic [PTR_W-1:0]   ptr_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // Index of the set bit; 0 for an all-zero vector.
    function automatic ptr_t onehot_to_idx(input onehot_t oh);
        ptr_t idx;
        idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (oh[i]) idx = ptr_t'(i);
        end
        return idx;
    endfunction

    function automatic ptr_t ptr_after(input ptr_t idx);
        return (idx == ptr_t'(N_PORTS - 1)) ? '0 : idx + ptr_t'(1);
    endfunction

endpackage

// File: rtl/crossbar_rr_arbiter_if.sv
// Request/grant bundle between the masters and one crossbar output port.
// slave = arbiter side, master = requester/downstream side.
interface crossbar_rr_arbiter_if;
    import crossbar_pkg::*;

    onehot_t req;
    onehot_t last;
    logic    out_ready;
    onehot_t grant;
    logic    out_valid;
    onehot_t gnt_ack;
    logic    busy;

    modport slave (
        input  req, last, out_ready,
        output grant, out_valid, gnt_ack, busy
    );

    modport master (
        output req, last, out_ready,
        input  grant, out_valid, gnt_ack, busy
    );
endinterface

// File: rtl/crossbar_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request scanning from i_ptr upward,
// wrapping from the top index back to 0.
module rr_pick
    import crossbar_pkg::*;
(
    input  onehot_t i_req,
    input  ptr_t    i_ptr,
    output onehot_t o_pick,
    output logic    o_any
);

    logic w_found;

    // NOTE: every output gets a default before the loop, otherwise the
    // paths that never assign it would infer a latch.
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            automatic int idx = int'(i_ptr) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (!w_found && i_req[idx]) begin
                o_pick[idx] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/crossbar_rr_arbiter.sv
// Round-robin arbiter for one crossbar output port: holds the grant for a
// whole burst and hands over to the next requester with no idle cycle.
module crossbar_rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crossbar_rr_arbiter_if.slave  bus
);

    // A zero cap still needs a legal one-bit counter.
    localparam int CNT_W = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);

    arb_state_t       r_state;
    onehot_t          r_grant;
    logic             r_busy;
    ptr_t             r_ptr;
    logic [CNT_W-1:0] r_cnt;

    ptr_t             w_g_idx;
    ptr_t             w_next_ptr;
    ptr_t             w_pick_ptr;
    onehot_t          w_pick;
    logic             w_any;
    logic             w_req_g;
    logic             w_beat;
    logic             w_last_g;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cap_hit;
    logic             w_release;

    assign w_g_idx    = onehot_to_idx(r_grant);
    assign w_next_ptr = ptr_after(w_g_idx);
    assign w_req_g    = |(r_grant & bus.req);
    assign w_last_g   = |(r_grant & bus.req & bus.last);
    assign w_beat     = (r_state == ARB_BUSY) && w_req_g && bus.out_ready;

    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_cap_hit  = (MAX_BEATS != 0) && (w_cnt_inc == CNT_W'(MAX_BEATS));

    assign w_release  = (r_state == ARB_BUSY) &&
                        (!w_req_g || (w_beat && (w_last_g || w_cap_hit)));

    // In BUSY the pick only matters on release, where it must scan from g+1.
    assign w_pick_ptr = (r_state == ARB_BUSY) ? w_next_ptr : r_ptr;

    rr_pick u_pick (
        .i_req  (bus.req),
        .i_ptr  (w_pick_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state <= ARB_BUSY;
                        r_busy  <= 1'b1;
                        r_grant <= w_pick;
                        r_cnt   <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        r_cnt <= '0;
                        if (w_any) begin
                            r_grant <= w_pick;
                        end else begin
                            r_grant <= '0;
                            r_state <= ARB_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_beat) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.out_valid = w_req_g;
    assign bus.gnt_ack   = r_grant & {N_PORTS{bus.out_ready}};
    assign bus.busy      = r_busy;

endmodule

// File: doc/crossbar_rr_arbiter.md
# crossbar_rr_arbiter

Round-robin arbiter for one crossbar output port. It arbitrates among six requesting masters and produces the one-hot select that drives the port's 6-to-1 one-hot data mux. A grant is held for the whole burst, until the master's last beat is accepted or the burst cap is reached, and then passes to the next requester in rotating order.

## Interface
- `MAX_BEATS`, default 16: burst cap in accepted beats; 0 disables the cap.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising edge of `clk`.
- `req`  in  6  per-master request; bit i asserted means master i has a valid beat.
- `last`  in  6  per-master last-beat flag; meaningful only together with `req[i]`.
- `out_ready`  in  1  downstream accepts the current beat.
- `grant`  out  6  registered one-hot grant, 6'b000000 when idle; drives the mux select directly.
- `out_valid`  out  1  combinational `|(grant & req)`.
- `gnt_ack`  out  6  combinational per-master ready, `grant & {6{out_ready}}`.
- `busy`  out  1  registered; high while the state is BUSY.

## Operation
- States:
  - IDLE: `grant` = 0.
  - BUSY: `grant` has exactly one bit set, called g.
- Priority pointer `ptr` (0..5) holds the index with the highest priority. The pick is the first set `req` bit scanning ptr, ptr+1, …, wrapping 5→0.
- IDLE → BUSY: when any `req` bit is set, `grant` takes the one-hot of the pick and the beat counter clears.
- Beat definition: `req[g] & out_ready` in BUSY. Each beat increments the beat counter.
- Release condition (BUSY), any of:
  - a beat with `last[g]`=1;
  - a beat that brings the count to `MAX_BEATS` (when `MAX_BEATS`≠0);
  - `req[g]`=0, meaning the master withdrew. Release takes effect the same cycle; nothing is recorded.
- On release:
  - `ptr` ← (g+1) mod 6.
  - The arbiter picks again from the current `req` starting at the new `ptr`. Master g is excluded only if its `req[g]` is low.
  - If a winner exists, `grant` moves directly to it and the state stays BUSY, with no idle bubble. Otherwise `grant` ← 0 and the state goes to IDLE.
- Non-granted masters' `req` bits are ignored during BUSY and must be held by the masters.
- `grant` never changes except on a release or on an IDLE pick.
- Beat counter width: `$clog2(MAX_BEATS+1)`. It saturates and never wraps.
- `last` bits of non-granted masters are ignored.

## Timing
- Reset values: `grant`=0, `busy`=0, `ptr`=0, beat counter=0, state IDLE. `out_valid` and `gnt_ack` are therefore 0.
- Arbitration latency: `req` seen in IDLE at edge t → `grant` valid after edge t. First beat possible in the cycle after edge t.
- Handover latency 0: the release beat at edge t loads the next grant at the same edge.
- Reset mid-burst: `grant` drops to 0 at the reset edge. The in-flight beat that cycle is not accepted.
- Simultaneous requests from all 6 masters, each doing single-beat bursts: grants rotate 0,1,2,3,4,5,0… one per cycle when `out_ready`=1.
- `out_ready` low: no beat and no count change; the grant holds indefinitely.

## Structure
- `crossbar_pkg`:
  - `N_PORTS`=6;
  - `typedef logic [N_PORTS-1:0] onehot_t`;
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t`.
- Sub-module `rr_pick`: combinational rotating priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `pick` and `any`.
  - Instantiated once and reused for both the IDLE pick and the handover pick.
- Beat counter, state, `ptr` and `grant` registers live in the top.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req`=6'h3F → `grant`=0 and `busy`=0 throughout. The first edge after release gives `grant`=6'b000001.
- Single-beat rotation: `req`=6'h3F, `last`=6'h3F, `out_ready`=1 → `grant` sequence 01,02,04,08,10,20,01 on consecutive cycles.
- Burst lock: master 2 requests a 5-beat burst with `out_ready` toggling 1,0,1,0…, and master 4 requests throughout → `grant`=6'b000100 for 9 cycles, then 6'b010000 at the edge of the 5th accepted beat.
- Burst cap: `MAX_BEATS`=4, master 0 holds `req` with `last`=0 → release after the 4th accepted beat. With only master 0 requesting, it is re-granted with the count cleared.
- Withdrawal: master 3 is granted, then `req[3]` drops mid-burst with no other requester → `grant`=0 and `busy`=0 at the next edge, and `ptr`=4.
- Reset mid-burst: assert `rst_n`=0 during beat 2 of a master 5 burst → `grant`=0 at that edge. After reset release, `req`=6'h21 gives `grant`=6'b000001 because `ptr` is back to 0.
